// File: rtl/dram_rd_arbiter.sv
// Merges N_TAU read-address/read-data lanes onto one DRAM read port: round-robin
// address grant, in-order response routing via a tag FIFO. DRAM_RD_ARB_PERF_EN adds perf counters.
module dram_rd_arbiter #(
    parameter int N_TAU          = 2,
    parameter int GLOBAL_ADDR_BW = 32,
    parameter int DATA_BW        = 32,
    parameter int CACHE_SIZE     = 4,
    parameter int GBW            = GLOBAL_ADDR_BW,
    parameter int LINE_BW        = DATA_BW * CACHE_SIZE,
    parameter int TAG_DEPTH      = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_TAU-1:0]       ra_rdys,
    input  logic [N_TAU*GBW-1:0]   ra_addrs,
    output logic [N_TAU-1:0]       ra_acks,
    output logic [N_TAU-1:0]       rd_rdys,
    output logic [LINE_BW-1:0]     rd_data,
    input  logic [N_TAU-1:0]       rd_acks,
    output logic                   dram_ra_rdy,
    output logic [GBW-1:0]         dram_ra_addr,
    input  logic                   dram_ra_ack,
    input  logic                   dram_rd_rdy,
    input  logic [LINE_BW-1:0]     dram_rd_data,
    output logic                   dram_rd_ack
`ifdef DRAM_RD_ARB_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_full_cnt
`endif
);
    localparam int LW = (N_TAU > 1) ? $clog2(N_TAU) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = $clog2(TAG_DEPTH + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [GBW-1:0]  addr_q, addr_d;
    logic [LW-1:0]   rr_q, rr_d;
    logic [LW-1:0]   tag_q [TAG_DEPTH];
    logic [LW-1:0]   tag_d [TAG_DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            full, empty, grant, pop, gnt_found;
    logic [LW-1:0]   gnt_idx, head;
    logic [LW:0]     lane_w;

    assign full  = (cnt_q == CW'(TAG_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = tag_q[rp_q];

    // Search starts one past the last winner; lane_w is wide enough to hold 2*N_TAU-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        lane_w    = '0;
        for (int j = 0; j < N_TAU; j++) begin
            lane_w = {1'b0, rr_q} + (LW+1)'(1) + (LW+1)'(j);
            if (lane_w >= (LW+1)'(N_TAU)) lane_w = lane_w - (LW+1)'(N_TAU);
            if (!gnt_found && ra_rdys[lane_w[LW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = lane_w[LW-1:0];
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign grant = !i_rst && gnt_found && !full && (state_q == IDLE || dram_ra_ack);

    always_comb begin
        ra_acks = '0;
        if (grant) ra_acks[gnt_idx] = 1'b1;
    end

    always_comb begin
        rd_rdys = '0;
        if (!empty && !i_rst) rd_rdys[head] = dram_rd_rdy;
    end

    assign dram_rd_ack  = !empty && !i_rst && rd_acks[head];
    assign rd_data      = dram_rd_data;
    assign pop          = dram_rd_rdy && dram_rd_ack;
    assign dram_ra_rdy  = (state_q == HOLD);
    assign dram_ra_addr = addr_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rr_d    = rr_q;
        tag_d   = tag_q;
        wr_d    = wr_q;
        rp_d    = rp_q;
        if (grant) begin
            state_d = HOLD;
            rr_d    = gnt_idx;
            for (int k = 0; k < N_TAU; k++)
                if (gnt_idx == LW'(k)) addr_d = ra_addrs[k*GBW +: GBW];
            tag_d[wr_q] = gnt_idx;
            wr_d        = wr_q + PW'(1);
        end else if (state_q == HOLD && dram_ra_ack) begin
            state_d = IDLE;
        end
        if (pop) rp_d = rp_q + PW'(1);
        cnt_d = cnt_q + CW'(grant) - CW'(pop);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rr_q    <= LW'(N_TAU - 1);
            wr_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
        tag_q <= tag_d;
    end

`ifdef DRAM_RD_ARB_PERF_EN
    logic [31:0] stall_q, stall_d, fullc_q, fullc_d;

    always_comb begin
        stall_d = stall_q;
        fullc_d = fullc_q;
        if (dram_ra_rdy && !dram_ra_ack && stall_q != '1) stall_d = stall_q + 32'd1;
        if ((|ra_rdys) && full && fullc_q != '1) fullc_d = fullc_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
            fullc_q <= '0;
        end else begin
            stall_q <= stall_d;
            fullc_q <= fullc_d;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_full_cnt  = fullc_q;
`endif
endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Directed bench for dram_rd_arbiter: stimulus pushes expected grants, DRAM addresses and
// responses into queues; a negedge monitor pops and compares whenever the DUT hands something off.
module tb_dram_rd_arbiter;
    localparam int N_TAU = 2, GBW = 32, LINE_BW = 128, TAG_DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 i_rst;
    logic [N_TAU-1:0]     ra_rdys, ra_acks, rd_rdys, rd_acks;
    logic [N_TAU*GBW-1:0] ra_addrs;
    logic [LINE_BW-1:0]   rd_data, dram_rd_data;
    logic                 dram_ra_rdy, dram_ra_ack, dram_rd_rdy, dram_rd_ack;
    logic [GBW-1:0]       dram_ra_addr;
`ifdef DRAM_RD_ARB_PERF_EN
    logic [31:0]          perf_stall_cnt, perf_full_cnt;
`endif

    always #5 clk = ~clk;

    dram_rd_arbiter #(.N_TAU(N_TAU), .GBW(GBW), .LINE_BW(LINE_BW), .TAG_DEPTH(TAG_DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .ra_rdys(ra_rdys), .ra_addrs(ra_addrs), .ra_acks(ra_acks),
        .rd_rdys(rd_rdys), .rd_data(rd_data), .rd_acks(rd_acks),
        .dram_ra_rdy(dram_ra_rdy), .dram_ra_addr(dram_ra_addr), .dram_ra_ack(dram_ra_ack),
        .dram_rd_rdy(dram_rd_rdy), .dram_rd_data(dram_rd_data), .dram_rd_ack(dram_rd_ack)
`ifdef DRAM_RD_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt)
`endif
    );

    typedef struct { int lane; logic [LINE_BW-1:0] data; } rd_exp_t;

    int          grant_q[$];
    logic [31:0] addr_q[$];
    rd_exp_t     rd_q[$];
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_grant(input int lane, input logic [31:0] a, input logic [LINE_BW-1:0] d);
        rd_exp_t e;
        e.lane = lane;
        e.data = d;
        grant_q.push_back(lane);
        addr_q.push_back(a);
        rd_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drain(input logic [LINE_BW-1:0] d);
        dram_rd_rdy  = 1'b1;
        rd_acks      = 2'b11;
        dram_rd_data = d;
        at_neg();
        step();
        dram_rd_rdy = 1'b0;
        rd_acks     = 2'b00;
    endtask

    // Monitor: inputs only change just after posedge, so a negedge handshake is the transfer.
    always @(negedge clk) begin
        if (!i_rst) begin
            if (ra_acks != '0) begin
                chk("ra_acks_onehot", 128'($onehot(ra_acks)), 128'(1));
                if (grant_q.size() == 0) chk("unexpected_grant", 128'(ra_acks), 128'(0));
                else chk("grant_lane", 128'(ra_acks), 128'(2'b01 << grant_q.pop_front()));
            end
            if (dram_ra_rdy && dram_ra_ack) begin
                if (addr_q.size() == 0) chk("unexpected_dram_addr", 128'(dram_ra_addr), 128'(0));
                else chk("dram_addr", 128'(dram_ra_addr), 128'(addr_q.pop_front()));
            end
            if ((rd_rdys & rd_acks) != '0) begin
                if (rd_q.size() == 0) chk("unexpected_rd", 128'(rd_rdys), 128'(0));
                else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_rdys", 128'(rd_rdys), 128'(2'b01 << e.lane));
                    chk("rd_data", rd_data, e.data);
                    chk("dram_rd_ack", 128'(dram_rd_ack), 128'(1));
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1; ra_rdys = 2'b11; ra_addrs = '0; rd_acks = 2'b11;
        dram_ra_ack = 1'b0; dram_rd_rdy = 1'b1; dram_rd_data = '0;
        step();
        at_neg();
        chk("rst_ra_acks", 128'(ra_acks), 128'(0));
        chk("rst_rd_rdys", 128'(rd_rdys), 128'(0));
        chk("rst_dram_rd_ack", 128'(dram_rd_ack), 128'(0));
        chk("rst_dram_ra_rdy", 128'(dram_ra_rdy), 128'(0));
        chk("rst_dram_ra_addr", 128'(dram_ra_addr), 128'(0));
        step();
        i_rst = 1'b0; ra_rdys = 2'b00; rd_acks = 2'b00; dram_rd_rdy = 1'b0;
`ifdef DRAM_RD_ARB_PERF_EN
        at_neg();
        chk("rst_perf_stall", 128'(perf_stall_cnt), 128'(0));
        chk("rst_perf_full", 128'(perf_full_cnt), 128'(0));
`endif
        step();

        // Both lanes requesting, ack held high: alternating addresses back to back.
        ra_addrs = {32'h200, 32'h100}; dram_ra_ack = 1'b1; ra_rdys = 2'b11;
        for (int i = 0; i < 4; i++) begin
            expect_grant(i % 2, (i % 2) ? 32'h200 : 32'h100, 128'h11 * (i + 1));
            at_neg(); step();
        end
        ra_rdys = 2'b00;
        at_neg(); step();
        for (int i = 0; i < 4; i++) drain(128'h11 * (i + 1));

        // Lane 1 alone with DRAM stalling for 5 cycles.
        ra_addrs[63:32] = 32'h2A0; dram_ra_ack = 1'b0; ra_rdys = 2'b10;
        expect_grant(1, 32'h2A0, 128'h55);
        at_neg(); step();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("hold_addr", 128'(dram_ra_addr), 128'h2A0);
            chk("hold_rdy", 128'(dram_ra_rdy), 128'(1));
            chk("hold_no_ack", 128'(ra_acks), 128'(0));
            step();
        end
        ra_rdys = 2'b00; dram_ra_ack = 1'b1;
        at_neg(); step();
`ifdef DRAM_RD_ARB_PERF_EN
        at_neg();
        chk("perf_stall", 128'(perf_stall_cnt), 128'(5));
        step();
`endif
        drain(128'h55);

        // Nine requests with no returns: eight granted, ninth waits past the pop cycle.
        ra_rdys = 2'b01;
        for (int k = 0; k < 8; k++) begin
            ra_addrs[31:0] = 32'h300 + k;
            expect_grant(0, 32'h300 + k, 128'h1000 + k);
            at_neg(); step();
        end
        ra_addrs[31:0] = 32'h308;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("full_block", 128'(ra_acks), 128'(0));
            step();
        end
        dram_rd_rdy = 1'b1; rd_acks = 2'b01; dram_rd_data = 128'h1000;
        at_neg();
        chk("no_bypass", 128'(ra_acks), 128'(0));
        step();
        dram_rd_rdy = 1'b0; rd_acks = 2'b00;
        expect_grant(0, 32'h308, 128'h1008);
        at_neg(); step();
        ra_rdys = 2'b00;
        at_neg(); step();
`ifdef DRAM_RD_ARB_PERF_EN
        at_neg();
        chk("perf_full", 128'(perf_full_cnt), 128'(4));
        step();
`endif
        for (int k = 1; k <= 8; k++) drain(128'h1000 + k);

        // In-order return across lanes; an ack from a non-head lane must not pop.
        ra_addrs = {32'h410, 32'h400};
        ra_rdys = 2'b01; expect_grant(0, 32'h400, 128'hA); at_neg(); step();
        ra_rdys = 2'b10; expect_grant(1, 32'h410, 128'hB); at_neg(); step();
        ra_rdys = 2'b01; expect_grant(0, 32'h400, 128'hC); at_neg(); step();
        ra_rdys = 2'b00; at_neg(); step();
        dram_rd_rdy = 1'b1; dram_rd_data = 128'hA; rd_acks = 2'b01; at_neg(); step();
        dram_rd_data = 128'hB; rd_acks = 2'b01;
        at_neg();
        chk("nonhead_rd_rdys", 128'(rd_rdys), 128'(2'b10));
        chk("nonhead_dram_ack", 128'(dram_rd_ack), 128'(0));
        step();
        rd_acks = 2'b10; at_neg(); step();
        dram_rd_data = 128'hC; rd_acks = 2'b01; at_neg(); step();
        dram_rd_rdy = 1'b0; rd_acks = 2'b00;

        // Three tags outstanding (last winner lane 0), then reset with late DRAM data.
        ra_addrs = {32'h510, 32'h500};
        ra_rdys = 2'b10; expect_grant(1, 32'h510, '0); at_neg(); step();
        ra_rdys = 2'b10; expect_grant(1, 32'h510, '0); at_neg(); step();
        ra_rdys = 2'b01; expect_grant(0, 32'h500, '0); at_neg(); step();
        ra_rdys = 2'b00; at_neg(); step();
        i_rst = 1'b1; dram_rd_rdy = 1'b1; rd_acks = 2'b11; dram_rd_data = 128'hBAD; ra_rdys = 2'b11;
        rd_q.delete();
        at_neg();
        chk("midrst_ra_acks", 128'(ra_acks), 128'(0));
        chk("midrst_rd_rdys", 128'(rd_rdys), 128'(0));
        chk("midrst_dram_rd_ack", 128'(dram_rd_ack), 128'(0));
        step();
        i_rst = 1'b0; ra_rdys = 2'b00;
        at_neg();
        chk("postrst_dram_ra_rdy", 128'(dram_ra_rdy), 128'(0));
        chk("postrst_rd_rdys", 128'(rd_rdys), 128'(0));
        chk("postrst_dram_rd_ack", 128'(dram_rd_ack), 128'(0));
`ifdef DRAM_RD_ARB_PERF_EN
        chk("postrst_perf_stall", 128'(perf_stall_cnt), 128'(0));
        chk("postrst_perf_full", 128'(perf_full_cnt), 128'(0));
`endif
        step();
        ra_rdys = 2'b11;
        expect_grant(0, 32'h500, 128'h77);
        at_neg();
        chk("late_data_no_ack", 128'(dram_rd_ack), 128'(0));
        step();
        dram_rd_rdy = 1'b0; rd_acks = 2'b00; ra_rdys = 2'b00;
        at_neg(); step();
        drain(128'h77);

        at_neg();
        chk("grant_q_empty", 128'(grant_q.size()), 128'(0));
        chk("addr_q_empty", 128'(addr_q.size()), 128'(0));
        chk("rd_q_empty", 128'(rd_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dram_rd_arbiter.md
DRAM_RD_ARBITER -- requirements
Module: dram_rd_arbiter

Interface
REQ-001 Parameter N_TAU, default 2, number of tau read-address/read-data lanes.
REQ-002 Parameter GBW, default GLOBAL_ADDR_BW, DRAM line address width.
REQ-003 Parameter LINE_BW, default DATA_BW*CACHE_SIZE, DRAM line data width.
REQ-004 Parameter TAG_DEPTH, default 8 (power of 2), maximum outstanding reads.
REQ-005 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-006 i_clk  in  1  clock; all state updates on rising edge.
REQ-007 i_rst  in  1  synchronous active-high reset.
REQ-008 ra_rdys  in  N_TAU  per-tau read-address request.
REQ-009 ra_addrs  in  N_TAU*GBW  per-tau line address; lane k at bits [k*GBW +: GBW].
REQ-010 ra_acks  out  N_TAU  per-tau address accept, at most one bit high.
REQ-011 rd_rdys  out  N_TAU  per-tau read-data valid, at most one bit high.
REQ-012 rd_data  out  LINE_BW  shared return data, valid for the lane with rd_rdys high.
REQ-013 rd_acks  in  N_TAU  per-tau read-data accept.
REQ-014 dram_ra_rdy / dram_ra_addr / dram_ra_ack  out 1 / out GBW / in 1  merged DRAM address channel.
REQ-015 dram_rd_rdy / dram_rd_data / dram_rd_ack  in 1 / in LINE_BW / out 1  merged DRAM data channel.

Function
REQ-016 A transfer on any rdy/ack pair SHALL occur only in a cycle where both are high.
REQ-017 Address path SHALL be an FSM: IDLE (dram_ra_rdy=0) and HOLD (dram_ra_rdy=1, dram_ra_addr registered).
REQ-018 Grant condition: state IDLE, or HOLD with dram_ra_ack=1; and ra_rdys!=0; and tag count < TAG_DEPTH.
REQ-019 On grant, ra_acks SHALL assert combinationally for exactly one lane g, selected round-robin starting at rr_ptr+1 mod N_TAU.
REQ-020 On grant, the block SHALL load ra_addrs lane g into dram_ra_addr, push g into the tag FIFO, set rr_ptr=g, and enter/stay in HOLD.
REQ-021 HOLD with dram_ra_ack=1 and no grant SHALL go to IDLE; HOLD without dram_ra_ack SHALL keep dram_ra_addr stable.
REQ-022 Sustained throughput SHALL be one address per cycle when dram_ra_ack is held high.
REQ-023 Tag count SHALL include the address held in HOLD; a tag pop in the same cycle SHALL NOT allow a grant at full count (no bypass).
REQ-024 Responses are in order: with FIFO non-empty and head h, rd_rdys[h]=dram_rd_rdy, rd_data=dram_rd_data, dram_rd_ack=rd_acks[h]; pop on dram_rd_rdy&dram_rd_ack.
REQ-025 With FIFO empty, rd_rdys=0 and dram_rd_ack=0 regardless of dram_rd_rdy.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo TAG_DEPTH.
REQ-027 rd_acks bits for non-head lanes SHALL be ignored.

Reset
REQ-028 On i_rst=1 at a clock edge: state IDLE, dram_ra_rdy=0, dram_ra_addr=0, rr_ptr=N_TAU-1, FIFO empty, count 0.
REQ-029 During reset ra_acks=0, rd_rdys=0, dram_rd_ack=0; reset mid-operation discards all outstanding tags, and late DRAM data is never acked.

Configuration
REQ-030 Macro DRAM_RD_ARB_PERF_EN defined: outputs perf_stall_cnt and perf_full_cnt (32 bits each, saturating, reset 0) SHALL count cycles with dram_ra_rdy&!dram_ra_ack and cycles with ra_rdys!=0 blocked by full count.
REQ-031 Macro DRAM_RD_ARB_PERF_EN undefined: both ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 ra_rdys=2'b11, addrs 0x100/0x200, dram_ra_ack=1 -> DRAM addresses 0x100,0x200,0x100... alternating from reset, ra_acks one-hot.
REQ-033 Single lane 1 requests, dram_ra_ack held low 5 cycles -> dram_ra_addr stable, no further ra_acks[1] while held, perf_stall_cnt=5 with macro.
REQ-034 9 requests, dram_rd_rdy=0 -> 8 granted, 9th stalls until one response pops, then granted next cycle (not same cycle).
REQ-035 Issue lane0, lane1, lane0; return data 0xA,0xB,0xC -> rd_rdys 01,10,01 with matching data; rd_acks[0] asserted while head is lane1 produces no pop.
REQ-036 Assert i_rst with 3 tags outstanding, then dram_rd_rdy=1 -> dram_ra_rdy=0, dram_rd_ack=0, rd_rdys=0; next grant goes to lane 0.
